// File: rtl/coprime_gcd_seq_pkg.sv
// coprime_pkg: shared FSM state type and latency bound for the coprime checker
package coprime_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int gcd_max_cycles(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/coprime_gcd_seq_gcd_step.sv
// gcd_step: one combinational binary (Stein) gcd iteration
module gcd_step #(
  parameter int W  = 8,
  parameter int KW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  na,
  output logic [W-1:0]  nb,
  output logic [KW-1:0] nk,
  output logic          done,
  output logic [W-1:0]  g
);
  logic ae, be, ge;
  assign ae   = ~a[0];
  assign be   = ~b[0];
  assign ge   = a >= b;
  assign done = a == '0 || b == '0;
  assign g    = (a | b) << k;
  assign na   = done ? a : ae ? a >> 1 : be ? a : ge ? (a - b) >> 1 : a;
  assign nb   = done ? b : (ae && be) ? b >> 1 : ae ? b : be ? b >> 1 : ge ? b : (b - a) >> 1;
  assign nk   = (!done && ae && be) ? k + 1'b1 : k;
endmodule

// File: rtl/coprime_gcd_seq.sv
// coprime_gcd_seq: handshaked sequential gcd and coprimality checker
module coprime_gcd_seq
  import coprime_pkg::*;
#(
  parameter int W         = 8,
  parameter bit LEGACY_EQ = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_gcd,
  output logic         out_coprime
);
  localparam int KW = $clog2(W + 1);
  state_t        state;
  logic [W-1:0]  a, b, ca, cb, na, nb, g;
  logic [KW-1:0] k, nk;
  logic          done;
  gcd_step #(.W(W), .KW(KW)) u_step (
    .a(a), .b(b), .k(k), .na(na), .nb(nb), .nk(nk), .done(done), .g(g)
  );
  // control FSM: capture operands, iterate one Stein step per cycle, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_gcd     <= '0;
      out_coprime <= 1'b0;
      a           <= '0;
      b           <= '0;
      ca          <= '0;
      cb          <= '0;
      k           <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a        <= in_a;
          b        <= in_b;
          ca       <= in_a;
          cb       <= in_b;
          k        <= '0;
          in_ready <= 1'b0;
          state    <= BUSY;
        end
        BUSY: if (done) begin
          out_gcd     <= g;
          out_coprime <= g == W'(1) && ca != '0 && cb != '0 && !(LEGACY_EQ && ca == cb);
          out_valid   <= 1'b1;
          state       <= DONE;
        end else begin
          a <= na;
          b <= nb;
          k <= nk;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_coprime_gcd_seq.sv
// tb_coprime_gcd_seq: directed and sweep checks on W=4 (both LEGACY_EQ) and W=8 instances
module tb_coprime_gcd_seq;
  import coprime_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] vld = '0;
  logic [7:0] in_a = '0, in_b = '0;
  logic       out_ready = 1'b1;
  logic       r4, r4n, r8, v4, v4n, v8, c4, c4n, c8;
  logic [3:0] g4, g4n;
  logic [7:0] g8;
  int         sel = 0;
  int         total = 0;
  int         bad = 0;
  always #5 clk = ~clk;
  coprime_gcd_seq #(.W(4), .LEGACY_EQ(1'b1)) d4 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(r4), .in_a(in_a[3:0]), .in_b(in_b[3:0]),
    .out_valid(v4), .out_ready(out_ready), .out_gcd(g4), .out_coprime(c4)
  );
  coprime_gcd_seq #(.W(4), .LEGACY_EQ(1'b0)) d4n (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(r4n), .in_a(in_a[3:0]), .in_b(in_b[3:0]),
    .out_valid(v4n), .out_ready(out_ready), .out_gcd(g4n), .out_coprime(c4n)
  );
  coprime_gcd_seq #(.W(8), .LEGACY_EQ(1'b1)) d8 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(r8), .in_a(in_a), .in_b(in_b),
    .out_valid(v8), .out_ready(out_ready), .out_gcd(g8), .out_coprime(c8)
  );

  function automatic logic cur_ready();
    return sel == 0 ? r4 : sel == 1 ? r4n : r8;
  endfunction
  function automatic logic cur_valid();
    return sel == 0 ? v4 : sel == 1 ? v4n : v8;
  endfunction
  function automatic logic [7:0] cur_gcd();
    return sel == 0 ? {4'b0, g4} : sel == 1 ? {4'b0, g4n} : g8;
  endfunction
  function automatic logic cur_cop();
    return sel == 0 ? c4 : sel == 1 ? c4n : c8;
  endfunction
  function automatic int gcd_ref(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic run(input int s, input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] g, output logic c, output int lat);
    int n = 0;
    sel = s;
    while (!cur_ready() && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!cur_ready()) begin
      bad++;
      $display("FAIL ready_wait dut=%0d in_ready=%b required 1", s, cur_ready());
    end
    in_a = a;
    in_b = b;
    vld[s] = 1'b1;
    @(negedge clk);
    vld[s] = 1'b0;
    lat = 0;
    while (!cur_valid() && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (!cur_valid()) begin
      bad++;
      $display("FAIL result_timeout dut=%0d a=%0d b=%0d out_valid=%b required 1", s, a, b, cur_valid());
    end
    total++;
    if (lat > gcd_max_cycles(s == 2 ? 8 : 4)) begin
      bad++;
      $display("FAIL latency dut=%0d a=%0d b=%0d got=%0d required<=%0d", s, a, b, lat, gcd_max_cycles(s == 2 ? 8 : 4));
    end
    g = cur_gcd();
    c = cur_cop();
    @(negedge clk);
    total++;
    if (cur_valid() !== 1'b0 || cur_ready() !== 1'b1) begin
      bad++;
      $display("FAIL handoff dut=%0d out_valid=%b in_ready=%b required 0,1", s, cur_valid(), cur_ready());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({r4, r4n, r8} !== 3'b111 || {v4, v4n, v8} !== 3'b000 || {c4, c4n, c8} !== 3'b000 ||
        g4 !== 4'd0 || g4n !== 4'd0 || g8 !== 8'd0) begin
      bad++;
      $display("FAIL reset ready=%b valid=%b cop=%b gcd=%0d,%0d,%0d required 111,000,000,0,0,0",
               {r4, r4n, r8}, {v4, v4n, v8}, {c4, c4n, c8}, g4, g4n, g8);
    end
  endtask

  task automatic test_vectors();
    int          tv [14][5] = '{
      '{0, 9, 4, 1, 1}, '{0, 12, 8, 4, 0}, '{0, 15, 10, 5, 0}, '{0, 7, 7, 7, 0},
      '{0, 1, 1, 1, 0}, '{1, 1, 1, 1, 1}, '{1, 7, 7, 7, 0}, '{1, 9, 4, 1, 1},
      '{0, 0, 5, 5, 0}, '{0, 0, 1, 1, 0}, '{0, 0, 0, 0, 0}, '{0, 5, 0, 5, 0},
      '{2, 255, 254, 1, 1}, '{2, 128, 96, 32, 0}};
    logic [7:0] g;
    logic       c;
    int         lat;
    for (int i = 0; i < 14; i++) begin
      run(tv[i][0], 8'(tv[i][1]), 8'(tv[i][2]), g, c, lat);
      total++;
      if (g !== 8'(tv[i][3]) || c !== 1'(tv[i][4])) begin
        bad++;
        $display("FAIL vector dut=%0d (%0d,%0d) got gcd=%0d cop=%b required gcd=%0d cop=%0d",
                 tv[i][0], tv[i][1], tv[i][2], g, c, tv[i][3], tv[i][4]);
      end
      if (tv[i][1] == 0 || tv[i][2] == 0) begin
        total++;
        if (lat > 2) begin
          bad++;
          $display("FAIL zero_latency (%0d,%0d) got=%0d required<=2", tv[i][1], tv[i][2], lat);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int errs = 0;
    sel = 0;
    out_ready = 1'b0;
    in_a = 8'd15;
    in_b = 8'd10;
    vld[0] = 1'b1;
    @(negedge clk);
    in_a = 8'd9;
    in_b = 8'd4;
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    while (!v4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      if (v4 !== 1'b1 || g4 !== 4'd5 || c4 !== 1'b0 || r4 !== 1'b0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL backpressure_hold bad_cycles=%0d last valid=%b gcd=%0d cop=%b ready=%b required 1,5,0,0",
               errs, v4, g4, c4, r4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (v4 !== 1'b0 || r4 !== 1'b1 || g4 !== 4'd5 || c4 !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_release valid=%b ready=%b gcd=%0d cop=%b required 0,1,5,0", v4, r4, g4, c4);
    end
  endtask

  task automatic test_mid_reset();
    int         seen = 0;
    logic [7:0] g;
    logic       c;
    int         lat;
    sel = 0;
    in_a = 8'd14;
    in_b = 8'd6;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (r4 !== 1'b1 || v4 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset ready=%b valid=%b required 1,0", r4, v4);
    end
    repeat (6) begin
      @(negedge clk);
      if (v4) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL mid_reset_no_result out_valid_cycles=%0d required 0", seen);
    end
    run(0, 8'd3, 8'd5, g, c, lat);
    total++;
    if (g !== 8'd1 || c !== 1'b1) begin
      bad++;
      $display("FAIL after_reset (3,5) got gcd=%0d cop=%b required 1,1", g, c);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g;
    logic       c;
    int         lat, eg;
    logic       ec;
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          run(s, 8'(x), 8'(y), g, c, lat);
          eg = gcd_ref(x, y);
          ec = eg == 1 && x != 0 && y != 0 && !(s == 0 && x == y);
          total++;
          if (g !== 8'(eg) || c !== ec) begin
            bad++;
            $display("FAIL sweep dut=%0d (%0d,%0d) got gcd=%0d cop=%b required gcd=%0d cop=%b", s, x, y, g, c, eg, ec);
          end
        end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
